// File: rtl/id_exe_skid_reg_if.sv
// Decode-to-execute bundle channel: input-side handshake and payload, flush,
// and the presented output bundle with its handshake.
interface id_exe_skid_reg_if #(
    parameter int DATA_W     = 32,
    parameter int CMD_W      = 4,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_pc;
    logic [DATA_W-1:0]     in_val1;
    logic [DATA_W-1:0]     in_val2;
    logic [DATA_W-1:0]     in_st_val;
    logic [CMD_W-1:0]      in_exe_cmd;
    logic [REG_ADDR_W-1:0] in_dest;
    logic                  in_wb_en;
    logic                  in_mem_r_en;
    logic                  in_mem_w_en;

    logic                  flush;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_pc;
    logic [DATA_W-1:0]     out_val1;
    logic [DATA_W-1:0]     out_val2;
    logic [DATA_W-1:0]     out_st_val;
    logic [CMD_W-1:0]      out_exe_cmd;
    logic [REG_ADDR_W-1:0] out_dest;
    logic                  out_wb_en;
    logic                  out_mem_r_en;
    logic                  out_mem_w_en;

    // The register itself.
    modport slave (
        input  in_valid, in_pc, in_val1, in_val2, in_st_val, in_exe_cmd, in_dest,
               in_wb_en, in_mem_r_en, in_mem_w_en, flush, out_ready,
        output in_ready, out_valid, out_pc, out_val1, out_val2, out_st_val,
               out_exe_cmd, out_dest, out_wb_en, out_mem_r_en, out_mem_w_en
    );

    // Whatever sits around the register (decode on one side, execute on the other).
    modport master (
        output in_valid, in_pc, in_val1, in_val2, in_st_val, in_exe_cmd, in_dest,
               in_wb_en, in_mem_r_en, in_mem_w_en, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_val1, out_val2, out_st_val,
               out_exe_cmd, out_dest, out_wb_en, out_mem_r_en, out_mem_w_en
    );
endinterface

// File: rtl/id_exe_skid_reg.sv
// ID/EXE pipeline register with a one-entry skid buffer so decode can stall on
// a registered ready; flush turns both held slots into bubbles.
module id_exe_skid_reg #(
    parameter int DATA_W     = 32,
    parameter int CMD_W      = 4,
    parameter int REG_ADDR_W = 5
) (
    input logic              clk,
    input logic              rst,
    id_exe_skid_reg_if.slave bus
);

    typedef struct packed {
        logic [DATA_W-1:0]     pc;
        logic [DATA_W-1:0]     val1;
        logic [DATA_W-1:0]     val2;
        logic [DATA_W-1:0]     st_val;
        logic [CMD_W-1:0]      exe_cmd;
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb_en;
        logic                  mem_r_en;
        logic                  mem_w_en;
    } bundle_t;

    bundle_t in_bundle;
    bundle_t main_q, main_d;
    bundle_t skid_q, skid_d;
    logic    main_vld_q, main_vld_d;
    logic    skid_vld_q, skid_vld_d;
    logic    accept;
    logic    consume;

    always_comb begin
        in_bundle.pc       = bus.in_pc;
        in_bundle.val1     = bus.in_val1;
        in_bundle.val2     = bus.in_val2;
        in_bundle.st_val   = bus.in_st_val;
        in_bundle.exe_cmd  = bus.in_exe_cmd;
        in_bundle.dest     = bus.in_dest;
        in_bundle.wb_en    = bus.in_wb_en;
        in_bundle.mem_r_en = bus.in_mem_r_en;
        in_bundle.mem_w_en = bus.in_mem_w_en;
    end

    // Ready depends only on skid occupancy, so there is no path from out_ready.
    assign accept  = bus.in_valid & ~skid_vld_q;
    assign consume = main_vld_q & bus.out_ready;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;

        if (bus.flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || consume) begin
            if (skid_vld_q) begin
                // The skid entry is older than anything at the input.
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d     = in_bundle;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (!skid_vld_q && accept) begin
            skid_d     = in_bundle;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign bus.in_ready    = ~skid_vld_q;
    assign bus.out_valid   = main_vld_q;
    assign bus.out_pc      = main_q.pc;
    assign bus.out_val1    = main_q.val1;
    assign bus.out_val2    = main_q.val2;
    assign bus.out_st_val  = main_q.st_val;
    assign bus.out_exe_cmd = main_q.exe_cmd;
    assign bus.out_dest    = main_q.dest;

    // A bubble must never write the register file or memory.
    assign bus.out_wb_en    = main_q.wb_en & main_vld_q;
    assign bus.out_mem_r_en = main_q.mem_r_en & main_vld_q;
    assign bus.out_mem_w_en = main_q.mem_w_en & main_vld_q;

endmodule
